// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter and instruction-fetch sequencer for the 8-bit MIPS core
// Optional macro PC_LINK_EN adds link_en/link_addr (return address captured on linked jumps).
module pc_sequencer #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    output logic              instr_valid,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_offset,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              halt,
`ifdef PC_LINK_EN
    input  logic              link_en,
    output logic [ADDR_W-1:0] link_addr,
`endif
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus1,
    output logic              halted,
    output logic              fetch_timeout
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_HALT  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    // Last wait count before timeout; timeout fires after MAX_WAIT unacked fetch cycles.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    logic [2:0]        r_state;
    logic [7:0]        r_wait;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_plus1;
    logic [ADDR_W-1:0] w_branch_pc;

    assign w_pc_plus1  = r_pc + 1'b1;
    assign w_branch_pc = w_pc_plus1 + branch_offset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_wait  <= '0;
            r_pc    <= RESET_PC;
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_FETCH;
                S_FETCH: begin
                    if (imem_ack) begin
                        r_state <= S_EXEC;
                        r_wait  <= '0;
                    end else if (r_wait == WAIT_LAST) begin
                        r_state <= S_ERROR;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                S_EXEC: begin
                    if (halt) begin
                        r_state <= S_HALT;
                    end else if (!stall) begin
                        r_state <= S_FETCH;
                        if (jump_en)
                            r_pc <= jump_target;
                        else if (branch_taken)
                            r_pc <= w_branch_pc;
                        else
                            r_pc <= w_pc_plus1;
                    end
                end
                S_HALT:  r_state <= S_HALT;
                S_ERROR: r_state <= S_ERROR;
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef PC_LINK_EN
    logic [ADDR_W-1:0] r_link_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_link_addr <= '0;
        else if (r_state == S_EXEC && !halt && !stall && jump_en && link_en)
            r_link_addr <= w_pc_plus1;
    end

    assign link_addr = r_link_addr;
`endif

    // All handshake/status outputs are pure state decodes so none depend on inputs.
    assign imem_req      = (r_state == S_FETCH);
    assign imem_addr     = r_pc;
    assign instr_valid   = (r_state == S_EXEC);
    assign halted        = (r_state == S_HALT);
    assign fetch_timeout = (r_state == S_ERROR);
    assign pc            = r_pc;
    assign pc_plus1      = w_pc_plus1;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic       instr_valid;
    logic       stall;
    logic       branch_taken;
    logic [7:0] branch_offset;
    logic       jump_en;
    logic [7:0] jump_target;
    logic       halt;
    logic [7:0] pc;
    logic [7:0] pc_plus1;
    logic       halted;
    logic       fetch_timeout;
`ifdef PC_LINK_EN
    logic       link_en;
    logic [7:0] link_addr;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    pc_sequencer #(.ADDR_W(8), .RESET_PC(8'h00), .MAX_WAIT(15)) u_dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .instr_valid   (instr_valid),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump_en       (jump_en),
        .jump_target   (jump_target),
        .halt          (halt),
`ifdef PC_LINK_EN
        .link_en       (link_en),
        .link_addr     (link_addr),
`endif
        .pc            (pc),
        .pc_plus1      (pc_plus1),
        .halted        (halted),
        .fetch_timeout (fetch_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    task automatic apply_reset(input logic ack);
        reset         = 1'b1;
        imem_ack      = ack;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_offset = 8'h00;
        jump_en       = 1'b0;
        jump_target   = 8'h00;
        halt          = 1'b0;
`ifdef PC_LINK_EN
        link_en       = 1'b0;
`endif
        step;
        step;
        chk("rst_pc", pc, 8'h00);
        chk("rst_pc_plus1", pc_plus1, 8'h01);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_timeout", fetch_timeout, 1'b0);
        reset = 1'b0;
    endtask

    // From an EXEC cycle with ack=1: jump to t, land in EXEC at t.
    task automatic jump_to(input logic [7:0] t);
        jump_en     = 1'b1;
        jump_target = t;
        step;
        chk("jt_req", imem_req, 1'b1);
        chk("jt_addr", imem_addr, t);
        jump_en = 1'b0;
        step;
        chk("jt_valid", instr_valid, 1'b1);
        chk("jt_pc", pc, t);
    endtask

    initial begin
        int cnt;

        // Sequential fetch with ack tied high
        apply_reset(1'b1);
        step;
        for (int i = 0; i < 4; i++) begin
            chk("seq_req", imem_req, 1'b1);
            chk("seq_addr", imem_addr, i);
            step;
            chk("seq_valid", instr_valid, 1'b1);
            chk("seq_req_low", imem_req, 1'b0);
            step;
        end
        step;
        chk("seq_pc4", pc, 8'h04);
        jump_to(8'hFE);
        step;
        chk("wrap_ff", imem_addr, 8'hFF);
        chk("wrap_ff_p1", pc_plus1, 8'h00);
        step;
        step;
        chk("wrap_00_req", imem_req, 1'b1);
        chk("wrap_00", imem_addr, 8'h00);
        step;

        // Branch backwards, then jump beats branch
        jump_to(8'h10);
        branch_taken  = 1'b1;
        branch_offset = 8'hFC;
        step;
        chk("br_addr", imem_addr, 8'h0D);
        branch_taken = 1'b0;
        step;
        jump_to(8'h10);
        branch_taken = 1'b1;
        jump_en      = 1'b1;
        jump_target  = 8'h80;
        step;
        chk("jmp_over_br", imem_addr, 8'h80);
        branch_taken = 1'b0;
        jump_en      = 1'b0;
        step;

        // Branch wrap: FE + 1 + 3 = 02
        jump_to(8'hFE);
        branch_taken  = 1'b1;
        branch_offset = 8'h03;
        step;
        chk("br_wrap", imem_addr, 8'h02);
        branch_taken = 1'b0;
        step;

        // Stall holds the instruction and masks the pending jump
        jump_to(8'h05);
        stall       = 1'b1;
        jump_en     = 1'b1;
        jump_target = 8'h40;
        for (int k = 0; k < 3; k++) begin
            step;
            chk("stall_valid", instr_valid, 1'b1);
            chk("stall_pc", pc, 8'h05);
            chk("stall_req", imem_req, 1'b0);
        end
        stall = 1'b0;
        step;
        chk("unstall_req", imem_req, 1'b1);
        chk("unstall_addr", imem_addr, 8'h40);
        jump_en = 1'b0;
        step;

        // Fetch timeout after 15 unacked cycles
        imem_ack = 1'b0;
        step;
        cnt = 0;
        while (imem_req && cnt < 40) begin
            cnt++;
            step;
        end
        chk("to_cycles", cnt, 15);
        chk("to_flag", fetch_timeout, 1'b1);
        chk("to_req", imem_req, 1'b0);
        chk("to_valid", instr_valid, 1'b0);
        chk("to_pc", pc, 8'h41);
        imem_ack = 1'b1;
        step;
        step;
        chk("to_sticky", fetch_timeout, 1'b1);
        chk("to_pc_frozen", pc, 8'h41);

        // Ack on the 15th fetch cycle wins over timeout
        apply_reset(1'b0);
        step;
        for (int k = 1; k < 15; k++) begin
            chk("late_req", imem_req, 1'b1);
            step;
        end
        chk("late_req15", imem_req, 1'b1);
        imem_ack = 1'b1;
        step;
        chk("late_valid", instr_valid, 1'b1);
        chk("late_no_to", fetch_timeout, 1'b0);

        // Halt freezes pc with no further fetches
        jump_to(8'h22);
        halt = 1'b1;
        step;
        chk("halt_flag", halted, 1'b1);
        chk("halt_valid", instr_valid, 1'b0);
        halt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step;
            chk("halt_req", imem_req, 1'b0);
            chk("halt_hold", halted, 1'b1);
            chk("halt_pc", pc, 8'h22);
        end

`ifdef PC_LINK_EN
        apply_reset(1'b1);
        step;
        step;
        jump_to(8'h30);
        chk("link_rst", link_addr, 8'h00);
        jump_en     = 1'b1;
        link_en     = 1'b1;
        jump_target = 8'h90;
        step;
        chk("link_addr", link_addr, 8'h31);
        chk("link_fetch", imem_addr, 8'h90);
        jump_en = 1'b0;
        link_en = 1'b0;
        step;
        jump_en     = 1'b1;
        jump_target = 8'h30;
        step;
        chk("link_hold", link_addr, 8'h31);
        chk("link_hold_fetch", imem_addr, 8'h30);
        jump_en = 1'b0;
        step;
`endif

        // Asynchronous reset in the middle of a fetch
        apply_reset(1'b1);
        step;
        step;
        jump_to(8'h33);
        imem_ack = 1'b0;
        step;
        chk("mid_req", imem_req, 1'b1);
        chk("mid_addr", imem_addr, 8'h34);
        #2 reset = 1'b1;
        #1;
        chk("async_req", imem_req, 1'b0);
        chk("async_pc", pc, 8'h00);
        chk("async_valid", instr_valid, 1'b0);
        step;
        reset    = 1'b0;
        imem_ack = 1'b1;
        step;
        chk("restart_req", imem_req, 1'b1);
        chk("restart_addr", imem_addr, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
